bnn_operand_loader: RTL and testbench

Upstream operand stage for the BNN neuron. It assembles 32-bit activation and weight words from an 8-bit byte stream, such as the TinyTapeout input pins, and presents each operand pair to the neuron with a valid/ready handshake. It tracks the word position within one neuron evaluation, so the neuron-side logic knows where each evaluation begins and ends.

---
 rtl/bnn_operand_loader.sv | 128 ++++++++++++
 tb/tb_bnn_operand_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bnn_operand_loader.sv
// Byte-stream operand loader for the BNN neuron: packs 8-bit bytes into 32-bit
// activation/weight words and hands each pair downstream with valid/ready.
module bnn_operand_loader #(
    parameter int WORDS = 4,
    parameter int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [7:0]      in_byte,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     input_data,
    output logic [31:0]     weight,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_first,
    output logic            out_last,
    output logic [IDXW-1:0] word_idx
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_X,
        LOAD_W,
        PRESENT
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    state_t          state, state_n;
    logic [1:0]      byte_cnt, byte_cnt_n;
    logic [31:0]     input_data_n, weight_n;
    logic            in_ready_n, out_valid_n, out_first_n, out_last_n;
    logic [IDXW-1:0] word_idx_n;
    logic            byte_xfer, out_xfer;

    assign byte_xfer = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // rst_n is active-high despite its name; it matches the rest of the chip.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            input_data <= 32'd0;
            weight     <= 32'd0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            word_idx   <= '0;
        end else begin
            state      <= state_n;
            byte_cnt   <= byte_cnt_n;
            input_data <= input_data_n;
            weight     <= weight_n;
            in_ready   <= in_ready_n;
            out_valid  <= out_valid_n;
            out_first  <= out_first_n;
            out_last   <= out_last_n;
            word_idx   <= word_idx_n;
        end
    end

    always_comb begin
        state_n      = state;
        byte_cnt_n   = byte_cnt;
        input_data_n = input_data;
        weight_n     = weight;
        in_ready_n   = in_ready;
        out_valid_n  = out_valid;
        out_first_n  = out_first;
        out_last_n   = out_last;
        word_idx_n   = word_idx;

        // flush wins over everything, including a byte or output transfer on the same edge.
        if (flush) begin
            state_n     = LOAD_X;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
            byte_cnt_n  = 2'd0;
            word_idx_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n    = LOAD_X;
                    in_ready_n = 1'b1;
                    byte_cnt_n = 2'd0;
                end
                LOAD_X: begin
                    if (byte_xfer) begin
                        input_data_n[{byte_cnt, 3'b000} +: 8] = in_byte;
                        byte_cnt_n = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state_n = LOAD_W;
                        end
                    end
                end
                LOAD_W: begin
                    if (byte_xfer) begin
                        weight_n[{byte_cnt, 3'b000} +: 8] = in_byte;
                        byte_cnt_n = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            in_ready_n  = 1'b0;
                            out_valid_n = 1'b1;
                            out_first_n = (word_idx == '0);
                            out_last_n  = (word_idx == LAST_IDX);
                            state_n     = PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (out_xfer) begin
                        out_valid_n = 1'b0;
                        in_ready_n  = 1'b1;
                        state_n     = LOAD_X;
                        word_idx_n  = (word_idx == LAST_IDX) ? '0 : word_idx + IDXW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_operand_loader.sv
// Directed bench for bnn_operand_loader (WORDS = 4): reset, streaming, backpressure,
// index wrap, flush, gapped input and asynchronous reset in PRESENT.
module tb_bnn_operand_loader;

    localparam int WORDS = 4;
    localparam int IDXW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [7:0]      in_byte;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     input_data;
    logic [31:0]     weight;
    logic            out_valid;
    logic            out_ready;
    logic            out_first;
    logic            out_last;
    logic [IDXW-1:0] word_idx;

    int errors = 0;
    int checks = 0;

    bnn_operand_loader #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input_data (input_data),
        .weight     (weight),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_first  (out_first),
        .out_last   (out_last),
        .word_idx   (word_idx)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Streams one pair LSB first, one byte per cycle; returns at the negedge after the 8th byte.
    task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            in_byte  = x[8*k +: 8];
            in_valid = 1'b1;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            in_byte  = w[8*k +: 8];
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic check_pair(input string tag, input logic [31:0] x, input logic [31:0] w,
                              input logic [31:0] idx, input logic first, input logic last);
        check_output({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_output({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        check_output({tag, ".input_data"}, input_data, x);
        check_output({tag, ".weight"}, weight, w);
        check_output({tag, ".word_idx"}, 32'(word_idx), idx);
        check_output({tag, ".first"}, 32'(out_first), 32'(first));
        check_output({tag, ".last"}, 32'(out_last), 32'(last));
    endtask

    initial begin
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        check_output("rst.in_ready", 32'(in_ready), 32'd0);
        check_output("rst.out_valid", 32'(out_valid), 32'd0);
        check_output("rst.input_data", input_data, 32'd0);
        check_output("rst.weight", weight, 32'd0);
        check_output("rst.word_idx", 32'(word_idx), 32'd0);
        check_output("rst.first_last", {30'd0, out_first, out_last}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("start.in_ready", 32'(in_ready), 32'd1);

        // Single pair with out_ready high: valid for exactly one cycle
        out_ready = 1'b1;
        apply_stimulus(32'h4433_2211, 32'hDDCC_BBAA);
        check_pair("pair0", 32'h4433_2211, 32'hDDCC_BBAA, 0, 1'b1, 1'b0);
        @(negedge clk);
        check_output("pair0.drop", 32'(out_valid), 32'd0);
        check_output("pair0.in_ready", 32'(in_ready), 32'd1);

        // Backpressure: outputs hold, 0xFF bytes ignored
        out_ready = 1'b0;
        apply_stimulus(32'h1234_5678, 32'h9ABC_DEF0);
        in_byte  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_pair("bp", 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0, 1'b0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_output("bp.drop", 32'(out_valid), 32'd0);
        check_output("bp.in_ready", 32'(in_ready), 32'd1);

        // Remaining pairs of the evaluation plus wrap to word 0
        apply_stimulus(32'hA0A1_A2A3, 32'hB0B1_B2B3);
        check_pair("pair2", 32'hA0A1_A2A3, 32'hB0B1_B2B3, 2, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(32'hC0C1_C2C3, 32'hD0D1_D2D3);
        check_pair("pair3", 32'hC0C1_C2C3, 32'hD0D1_D2D3, 3, 1'b0, 1'b1);
        @(negedge clk);
        apply_stimulus(32'hE0E1_E2E3, 32'hF0F1_F2F3);
        check_pair("wrap", 32'hE0E1_E2E3, 32'hF0F1_F2F3, 0, 1'b1, 1'b0);
        @(negedge clk);

        // Flush after 5 bytes of word 1; the byte on the flush edge is dropped
        for (int k = 0; k < 5; k++) begin
            in_byte  = 8'h50 + 8'(k);
            in_valid = 1'b1;
            @(negedge clk);
        end
        flush   = 1'b1;
        in_byte = 8'hEE;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check_output("flush.out_valid", 32'(out_valid), 32'd0);
        check_output("flush.in_ready", 32'(in_ready), 32'd1);
        apply_stimulus(32'h0102_0304, 32'h0506_0708);
        check_pair("flush.pair", 32'h0102_0304, 32'h0506_0708, 0, 1'b1, 1'b0);
        @(negedge clk);

        // Gapped input: a byte every other cycle, pair held in PRESENT
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_byte  = 8'h10 + 8'(i);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            in_byte  = 8'hA5;
            if (i == 6) begin
                check_output("gap.early", 32'(out_valid), 32'd0);
            end
            if (i < 7) begin
                @(negedge clk);
            end
        end
        check_pair("gap", 32'h1312_1110, 32'h1716_1514, 1, 1'b0, 1'b0);

        // Asynchronous reset while presenting
        #2;
        rst_n = 1'b1;
        #1;
        check_output("arst.out_valid", 32'(out_valid), 32'd0);
        check_output("arst.word_idx", 32'(word_idx), 32'd0);
        check_output("arst.input_data", input_data, 32'd0);
        check_output("arst.in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
